// File: rtl/inst_fetch.sv
// ============================================================================
//  inst_fetch : credit-based instruction fetch with PC tag queue and decode FIFO
//  Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        pc_valid_i,
   output logic        pc_ready_o,
   input  logic        flush_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW+1:0] C_DEPTH_W = (CW+2)'(DEPTH);
   localparam logic [PW-1:0] C_PTR_ONE = PW'(1);

   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_discard;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_tag_wr;
   logic [PW-1:0] r_tag_rd;
   logic [PW-1:0] r_fifo_wr;
   logic [PW-1:0] r_fifo_rd;
   logic [31:0]   r_tag   [DEPTH];
   logic [31:0]   r_fpc   [DEPTH];
   logic [31:0]   r_finst [DEPTH];

   logic [CW+1:0] w_occ;
   logic          w_credit;
   logic          w_req;
   logic          w_grant;
   logic          w_has_disc;
   logic          w_has_infl;
   logic          w_drop;
   logic          w_resp;
   logic          w_keep;
   logic          w_nonempty;
   logic          w_pop;

   // Credit uses start-of-cycle occupancy so a kept response always finds a free slot.
   assign w_occ      = {2'b00, r_inflight} + {2'b00, r_discard} + {2'b00, r_count};
   assign w_credit   = (w_occ < C_DEPTH_W);
   assign w_req      = pc_valid_i & w_credit & ~flush_i & ~rst;
   assign w_grant    = w_req & imem_gnt_i;

   assign w_has_disc = (r_discard != '0);
   assign w_has_infl = (r_inflight != '0);
   assign w_drop     = imem_rvalid_i & w_has_disc;
   assign w_resp     = imem_rvalid_i & (w_has_disc | w_has_infl);
   assign w_keep     = imem_rvalid_i & ~w_has_disc & w_has_infl & ~flush_i;

   assign w_nonempty = (r_count != '0);
   assign w_pop      = w_nonempty & id_ready_i & ~flush_i;

   assign imem_req_o  = w_req;
   assign imem_addr_o = pc_i;
   assign pc_ready_o  = w_grant;

   assign id_valid_o  = w_nonempty & ~rst;
   assign id_pc_o     = id_valid_o ? r_fpc[r_fifo_rd]   : 32'h0;
   assign id_inst_o   = id_valid_o ? r_finst[r_fifo_rd] : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_inflight <= '0;
         r_discard  <= '0;
         r_count    <= '0;
         r_tag_wr   <= '0;
         r_tag_rd   <= '0;
         r_fifo_wr  <= '0;
         r_fifo_rd  <= '0;
      end else begin
         if (w_grant) begin
            r_tag_wr <= r_tag_wr + C_PTR_ONE;
         end
         // Every accounted response retires one tag, whether kept or dropped.
         if (w_resp) begin
            r_tag_rd <= r_tag_rd + C_PTR_ONE;
         end
         if (flush_i) begin
            r_inflight <= '0;
            r_discard  <= r_discard + r_inflight - CW'(w_resp);
            r_count    <= '0;
            r_fifo_wr  <= '0;
            r_fifo_rd  <= '0;
         end else begin
            r_inflight <= r_inflight + CW'(w_grant) - CW'(w_keep);
            r_discard  <= r_discard - CW'(w_drop);
            r_count    <= r_count + CW'(w_keep) - CW'(w_pop);
            if (w_keep) begin
               r_fifo_wr <= r_fifo_wr + C_PTR_ONE;
            end
            if (w_pop) begin
               r_fifo_rd <= r_fifo_rd + C_PTR_ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_grant) begin
         r_tag[r_tag_wr] <= pc_i;
      end
      if (w_keep & ~rst) begin
         r_fpc[r_fifo_wr]   <= r_tag[r_tag_rd];
         r_finst[r_fifo_wr] <= imem_rdata_i;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// ============================================================================
//  tb_inst_fetch : directed + random scoreboard bench for inst_fetch
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_inst_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic        pc_valid_i;
   logic        pc_ready_o;
   logic        flush_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        id_valid_o;
   logic        id_ready_i;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;

   inst_fetch #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .pc_valid_i   (pc_valid_i),
      .pc_ready_o   (pc_ready_o),
      .flush_i      (flush_i),
      .imem_req_o   (imem_req_o),
      .imem_addr_o  (imem_addr_o),
      .imem_gnt_i   (imem_gnt_i),
      .imem_rvalid_i(imem_rvalid_i),
      .imem_rdata_i (imem_rdata_i),
      .id_valid_o   (id_valid_o),
      .id_ready_i   (id_ready_i),
      .id_pc_o      (id_pc_o),
      .id_inst_o    (id_inst_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_q [$];
   logic [31:0] exp_q [$];
   logic [31:0] dlv_q [$];
   int m_infl = 0;
   int m_disc = 0;
   int m_cnt  = 0;
   int n_rdy  = 0;

   logic        b_pcv  = 1'b0;
   logic        b_gnt  = 1'b0;
   logic        b_rv   = 1'b0;
   logic        b_idr  = 1'b0;
   logic        b_fl   = 1'b0;
   logic        b_spur = 1'b0;
   logic [31:0] b_pc   = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check combinational outputs and counters against
   // the reference model, then advance the model across the rising edge.
   task automatic tick();
      logic        exp_req;
      logic        granted;
      logic        resp;
      logic        keep;
      logic        pop;
      logic [31:0] e;
      rst           = 1'b0;
      pc_i          = b_pc;
      pc_valid_i    = b_pcv;
      imem_gnt_i    = b_gnt;
      id_ready_i    = b_idr;
      flush_i       = b_fl;
      imem_rvalid_i = b_rv & ((mem_q.size() > 0) | b_spur);
      imem_rdata_i  = (mem_q.size() > 0) ? mem_word(mem_q[0]) : $urandom;
      #1;
      exp_req = b_pcv && (m_infl + m_disc + m_cnt < DEPTH) && !b_fl;
      chk("imem_req", 32'(imem_req_o), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr_o, b_pc);
      chk("pc_ready", 32'(pc_ready_o), 32'(exp_req & b_gnt));
      chk("id_valid", 32'(id_valid_o), 32'(m_cnt != 0));
      chk("cnt_inflight", 32'(dut.r_inflight), 32'(m_infl));
      chk("cnt_discard", 32'(dut.r_discard), 32'(m_disc));
      chk("cnt_count", 32'(dut.r_count), 32'(m_cnt));
      if (m_cnt == 0) begin
         chk("id_pc_idle", id_pc_o, 32'h0);
         chk("id_inst_idle", id_inst_o, 32'h0);
      end
      if (pc_ready_o) n_rdy++;
      pop = (m_cnt != 0) && b_idr && !b_fl;
      if (pop) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc_o, e);
            chk("id_inst", id_inst_o, mem_word(e));
            dlv_q.push_back(id_pc_o);
         end
      end
      granted = exp_req & b_gnt;
      resp    = imem_rvalid_i && (m_infl + m_disc > 0);
      if (imem_rvalid_i && mem_q.size() > 0) void'(mem_q.pop_front());
      if (b_fl) begin
         m_disc = m_disc + m_infl - (resp ? 1 : 0);
         m_infl = 0;
         m_cnt  = 0;
         exp_q.delete();
      end else begin
         keep = resp && (m_disc == 0);
         if (resp && m_disc > 0) m_disc--;
         if (keep) begin
            m_infl--;
            m_cnt++;
         end
         if (pop) m_cnt--;
         if (granted) begin
            m_infl++;
            exp_q.push_back(b_pc);
         end
      end
      if (granted) mem_q.push_back(b_pc);
      @(posedge clk);
      #1;
      if (granted) b_pc = b_pc + 32'd4;
   endtask

   task automatic drain();
      b_pcv = 1'b0;
      b_idr = 1'b1;
      b_rv  = 1'b1;
      b_fl  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem_q.size() == 0 && m_cnt == 0) break;
         tick();
      end
      chk("drain_left", 32'(mem_q.size() + m_cnt), 32'd0);
   endtask

   initial begin
      int base;
      int g;
      // Reset with requests pending: nothing may leak out.
      rst           = 1'b1;
      pc_i          = 32'h0;
      pc_valid_i    = 1'b1;
      imem_gnt_i    = 1'b1;
      flush_i       = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      id_ready_i    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req", 32'(imem_req_o), 32'd0);
      chk("rst_pc_ready", 32'(pc_ready_o), 32'd0);
      chk("rst_id_valid", 32'(id_valid_o), 32'd0);
      chk("rst_id_pc", id_pc_o, 32'h0);
      chk("rst_id_inst", id_inst_o, 32'h0);

      // Streaming fetch from address 0
      b_pc = 32'h0; b_pcv = 1'b1; b_gnt = 1'b1; b_idr = 1'b1; b_rv = 1'b1;
      repeat (12) tick();
      chk("seq_len_ok", 32'(dlv_q.size() >= 3), 32'd1);
      if (dlv_q.size() >= 3) begin
         chk("seq0", dlv_q[0], 32'h0);
         chk("seq1", dlv_q[1], 32'h4);
         chk("seq2", dlv_q[2], 32'h8);
      end
      drain();

      // Decode stalled: credit exhausts, one pop buys exactly one request
      b_pcv = 1'b1; b_gnt = 1'b1; b_idr = 1'b0; b_rv = 1'b1;
      repeat (5) tick();
      chk("stall_req", 32'(imem_req_o), 32'd0);
      chk("stall_pc_ready", 32'(pc_ready_o), 32'd0);
      g = n_rdy;
      b_idr = 1'b1;
      tick();
      b_idr = 1'b0;
      repeat (4) tick();
      chk("one_pop_one_req", 32'(n_rdy - g), 32'd1);
      drain();

      // Flush with two requests in flight
      b_pcv = 1'b1; b_gnt = 1'b1; b_idr = 1'b0; b_rv = 1'b0;
      tick();
      tick();
      chk("two_inflight", 32'(dut.r_inflight), 32'd2);
      b_fl = 1'b1; b_pc = 32'h0000_1000;
      tick();
      b_fl = 1'b0;
      chk("flush_id_valid", 32'(id_valid_o), 32'd0);
      tick();
      base = dlv_q.size();
      b_rv = 1'b1; b_idr = 1'b1;
      repeat (6) tick();
      chk("redirect_delivered", 32'(dlv_q.size() > base), 32'd1);
      if (dlv_q.size() > base) chk("redirect_pc", dlv_q[base], 32'h0000_1000);
      drain();

      // Flush coinciding with a response while the FIFO holds an entry
      b_pcv = 1'b1; b_gnt = 1'b1; b_idr = 1'b0; b_rv = 1'b1;
      tick();
      tick();
      b_fl = 1'b1;
      tick();
      b_fl = 1'b0;
      chk("flush_rsp_count", 32'(dut.r_count), 32'd0);
      chk("flush_rsp_discard", 32'(dut.r_discard), 32'd0);
      chk("flush_rsp_id_valid", 32'(id_valid_o), 32'd0);
      b_pc = 32'h0000_2000; b_idr = 1'b1;
      repeat (5) tick();
      drain();

      // Spurious response with nothing outstanding
      b_pcv = 1'b0; b_rv = 1'b1; b_spur = 1'b1;
      tick();
      b_spur = 1'b0;
      chk("spur_count", 32'(dut.r_count), 32'd0);
      chk("spur_inflight", 32'(dut.r_inflight), 32'd0);
      chk("spur_discard", 32'(dut.r_discard), 32'd0);
      chk("spur_id_valid", 32'(id_valid_o), 32'd0);

      // Random traffic with occasional redirects
      for (int i = 0; i < 400; i++) begin
         b_pcv = ($urandom % 4) != 0;
         b_gnt = ($urandom % 3) != 0;
         b_rv  = ($urandom % 2) != 0;
         b_idr = ($urandom % 3) != 0;
         b_fl  = ($urandom % 30) == 0;
         if (b_fl) b_pc = $urandom & 32'h0000_FFFC;
         tick();
      end
      b_fl = 1'b0;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: DEPTH, 2, maximum instructions in flight plus buffered; power of two, >= 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pc_i  input  32  fetch address from the PC stage.
REQ-005 pc_valid_i  input  1  PC stage chip-enable; pc_i is valid.
REQ-006 pc_ready_o  output  1  pc_i consumed this cycle; the PC stage advances only when this is high.
REQ-007 flush_i  input  1  discard all buffered and in-flight fetches (branch/exception redirect).
REQ-008 imem_req_o  output  1  instruction memory request valid.
REQ-009 imem_addr_o  output  32  request address; equals pc_i.
REQ-010 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-011 imem_rvalid_i  input  1  read data valid; responses return in request order, at least 1 cycle after grant.
REQ-012 imem_rdata_i  input  32  instruction word.
REQ-013 id_valid_o  output  1  instruction available to decode.
REQ-014 id_ready_i  input  1  decode accepts the head instruction.
REQ-015 id_pc_o  output  32  PC of the head instruction.
REQ-016 id_inst_o  output  32  head instruction word.

Function
REQ-017 The block SHALL track inflight (granted, response pending, to be kept), discard (granted, response pending, to be dropped) and count (FIFO entries), each 0..DEPTH.
REQ-018 The block SHALL have credit available when inflight + discard + count < DEPTH, using the pre-update values of the current cycle.
REQ-019 imem_req_o SHALL equal pc_valid_i & credit & ~flush_i & ~rst, combinationally; imem_addr_o = pc_i.
REQ-020 pc_ready_o SHALL equal imem_req_o & imem_gnt_i; a grant is a handshake.
REQ-021 On grant, pc_i SHALL be pushed into a DEPTH-entry PC tag queue and inflight SHALL be incremented.
REQ-022 On imem_rvalid_i with discard > 0, discard SHALL be decremented, the oldest tag popped and the data dropped.
REQ-023 On imem_rvalid_i with discard = 0 and inflight > 0, the oldest tag and imem_rdata_i SHALL be written to the FIFO tail, inflight decremented, count incremented.
REQ-024 imem_rvalid_i with inflight = 0 and discard = 0 SHALL be ignored.
REQ-025 id_valid_o SHALL equal (count != 0); id_pc_o/id_inst_o SHALL present the FIFO head, and 0 when count = 0.
REQ-026 id_valid_o & id_ready_i SHALL pop the head; push and pop in the same cycle SHALL leave count unchanged.
REQ-027 Minimum latency SHALL be one cycle: a response kept at edge N drives id_valid_o high after edge N.
REQ-028 Credit accounting SHALL guarantee that a kept response never meets a full FIFO; no backpressure exists toward memory.
REQ-029 On flush_i: no request SHALL issue that cycle; FIFO count and pointers SHALL clear; discard <= discard + inflight, minus 1 if imem_rvalid_i; inflight <= 0; a response in the flush cycle SHALL be dropped; id pop SHALL be ignored.
REQ-030 Instruction order to decode SHALL equal grant order; no duplicate or lost kept instruction.
REQ-031 Counter arithmetic SHALL be saturating-free; overflow is prevented by REQ-018.

Reset
REQ-032 While rst is high, the block SHALL drive imem_req_o=0, pc_ready_o=0, id_valid_o=0, id_pc_o=0 and id_inst_o=0.
REQ-033 rst SHALL clear inflight, discard, count and all pointers; responses to requests granted before reset are dropped only when the memory also resets.
REQ-034 rst SHALL take priority over flush_i and all handshakes.

Verification
REQ-035 Reset, then pc_valid_i=1 with gnt and rvalid one cycle later, id_ready_i=1 -> id_pc_o sequence 0x0,0x4,0x8 with matching words and full throughput after fill.
REQ-036 id_ready_i=0 with DEPTH=2 -> after 2 grants imem_req_o=0 and pc_ready_o=0; one pop -> exactly one new request.
REQ-037 Flush with 2 in flight -> both responses dropped, id_valid_o=0, next grant address is the new pc_i, and its data is delivered.
REQ-038 Flush in the same cycle as a response, with FIFO non-empty -> response dropped, count=0, discard correct.
REQ-039 Random gnt/rvalid delays and id_ready_i -> scoreboard matches grant order, no loss, counters within 0..DEPTH.
REQ-040 Spurious imem_rvalid_i with nothing outstanding -> no state change.
